hyperram_ctrl: RTL and testbench



---
 rtl/hyperram_pkg.sv | 32 +++
 rtl/hyperram_ca_builder.sv | 20 ++
 rtl/hyperram_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_hyperram_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// Shared types and constants for the single-transaction HyperBus master.
// States, command/address field positions and phase lengths.
package hyperram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        WR,
        RD,
        REC,
        DONE
    } state_e;

    localparam int CA_W         = 48;
    localparam int CA_BYTES     = 6;
    localparam int DATA_BYTES   = 4;

    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_MSB   = 44;
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_COL_MSB   = 2;
    localparam int CA_COL_LSB   = 0;

    // ck only toggles while the device is being clocked for CA, latency or data.
    function automatic logic is_clocked(input state_e s);
        return (s == CA) || (s == LAT) || (s == WR) || (s == RD);
    endfunction

endpackage

// File: rtl/hyperram_ca_builder.sv
// Combinational builder of the 48-bit HyperBus command/address word
// (linear burst, memory space) from a word request.
module hyperram_ca_builder
    import hyperram_pkg::*;
(
    input  logic            write_enable,
    input  logic [31:0]     address,
    output logic [CA_W-1:0] ca
);

    always_comb begin
        ca                           = '0;
        ca[CA_RW_BIT]                = ~write_enable;
        ca[CA_AS_BIT]                = 1'b0;
        ca[CA_BURST_BIT]             = 1'b1;
        ca[CA_ROW_MSB:CA_ROW_LSB]    = address[31:3];
        ca[CA_COL_MSB:CA_COL_LSB]    = address[2:0];
    end

endmodule

// File: rtl/hyperram_ctrl.sv
// Single-transaction HyperBus (HyperRAM) master: CA, latency, 4 data bytes, recovery.
// Define HYPERRAM_ASSERT_EN to compile in embedded protocol assertions.
//
// state | meaning
// IDLE  | cs_n high, waiting for transaction_begin
// CA    | 6 command/address bytes driven on dq
// LAT   | initial latency, bus released
// WR    | 4 write bytes on dq, byte mask on rwds
// RD    | 4 read bytes captured (fixed timing or rwds edges)
// REC   | recovery with cs_n still low
// DONE  | cs_n high, one-cycle done (and error) pulse
module hyperram_ctrl
    import hyperram_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transaction_begin,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [3:0]  write_mask,
    input  logic [31:0] data_in,
    input  logic [5:0]  wait_latency,
    input  logic [5:0]  done_latency,
    input  logic        timed_read,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ck,
    output logic        cs_n,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    input  logic [7:0]  dq_in,
    output logic        rwds_out,
    output logic        rwds_oe,
    input  logic        rwds_in
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [CA_W-1:0] ca_q, ca_d, ca_req;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_out_q, data_out_d;
    logic            we_q, we_d;
    logic            timed_q, timed_d;
    logic            err_q, err_d;
    logic            ck_q, ck_d;
    logic            rwds_prev_q, rwds_prev_d;
    logic            go_lat, go_data, go_rec;
    logic [2:0]      byte_sel;

    // cnt_q counts down, so it also selects the byte: highest byte goes first.
    assign byte_sel = cnt_q[2:0];

    hyperram_ca_builder u_ca_builder (
        .write_enable (write_enable),
        .address      (address),
        .ca           (ca_req)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        ca_d        = ca_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        data_out_d  = data_out_q;
        we_d        = we_q;
        timed_d     = timed_q;
        err_d       = err_q;
        rwds_prev_d = rwds_in;
        go_lat      = 1'b0;
        go_data     = 1'b0;
        go_rec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (transaction_begin) begin
                    ca_d    = ca_req;
                    we_d    = write_enable;
                    mask_d  = write_mask;
                    wdata_d = data_in;
                    timed_d = timed_read;
                    err_d   = 1'b0;
                    cnt_d   = 7'(CA_BYTES - 1);
                    state_d = CA;
                end
            end
            CA: begin
                if (cnt_q == 7'd0) begin
                    if (wait_latency != 6'd0) go_lat = 1'b1;
                    else                      go_data = 1'b1;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            LAT: begin
                if (cnt_q == 7'd0) go_data = 1'b1;
                else               cnt_d = cnt_q - 7'd1;
            end
            WR: begin
                if (cnt_q == 7'd0) go_rec = 1'b1;
                else               cnt_d = cnt_q - 7'd1;
            end
            RD: begin
                if (timed_q || (rwds_in != rwds_prev_q)) begin
                    data_out_d[{byte_sel[1:0], 3'b000} +: 8] = dq_in;
                    tmo_d = TMO_LOAD;
                    if (cnt_q == 7'd0) go_rec = 1'b1;
                    else               cnt_d = cnt_q - 7'd1;
                end else if (tmo_q <= 8'd1) begin
                    err_d  = 1'b1;
                    go_rec = 1'b1;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            REC: begin
                if (cnt_q == 7'd0) state_d = DONE;
                else               cnt_d = cnt_q - 7'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_lat) begin
            state_d = LAT;
            cnt_d   = {wait_latency, 1'b0} - 7'd1;
        end
        if (go_data) begin
            state_d = we_q ? WR : RD;
            cnt_d   = 7'(DATA_BYTES - 1);
            tmo_d   = TMO_LOAD;
        end
        if (go_rec) begin
            if (done_latency != 6'd0) begin
                state_d = REC;
                cnt_d   = {done_latency, 1'b0} - 7'd1;
            end else begin
                state_d = DONE;
            end
        end

        // Toggling on every clocked edge leaves ck low again when the data phase ends.
        ck_d = (is_clocked(state_q) && is_clocked(state_d)) ? ~ck_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ca_q        <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            we_q        <= 1'b0;
            timed_q     <= 1'b0;
            err_q       <= 1'b0;
            ck_q        <= 1'b0;
            rwds_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ca_q        <= ca_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            we_q        <= we_d;
            timed_q     <= timed_d;
            err_q       <= err_d;
            ck_q        <= ck_d;
            rwds_prev_q <= rwds_prev_d;
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = 1'b0;
        error    = 1'b0;
        cs_n     = 1'b0;
        dq_out   = 8'h00;
        dq_oe    = 1'b0;
        rwds_out = 1'b0;
        rwds_oe  = 1'b0;
        unique case (state_q)
            IDLE: cs_n = 1'b1;
            CA: begin
                dq_oe  = 1'b1;
                dq_out = ca_q[{byte_sel, 3'b000} +: 8];
            end
            WR: begin
                dq_oe    = 1'b1;
                rwds_oe  = 1'b1;
                dq_out   = wdata_q[{byte_sel[1:0], 3'b000} +: 8];
                rwds_out = ~mask_q[byte_sel[1:0]];
            end
            DONE: begin
                cs_n  = 1'b1;
                done  = 1'b1;
                error = err_q;
            end
            default: ;
        endcase
    end

    assign ck       = ck_q;
    assign data_out = data_out_q;

`ifdef HYPERRAM_ASSERT_EN
    logic done_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= done;
            a_idle_cs:   assert (state_q != IDLE || cs_n);
            a_bus_free:  assert (!(state_q inside {LAT, RD, REC}) || !dq_oe);
            a_done_once: assert (!(done && done_prev_q));
            a_ck_low:    assert (!cs_n || !ck);
        end
    end
`else
`endif

endmodule

// File: tb/tb_hyperram_ctrl.sv
// Directed self-checking bench for hyperram_ctrl: reads, writes, latency,
// rwds-edge capture, timeout abort, mid-transaction reset and ignored requests.
module tb_hyperram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        transaction_begin;
    logic        write_enable;
    logic [31:0] address;
    logic [3:0]  write_mask;
    logic [31:0] data_in;
    logic [5:0]  wait_latency;
    logic [5:0]  done_latency;
    logic        timed_read;
    logic [31:0] data_out;
    logic        busy, done, error, ck, cs_n;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic [7:0]  dq_in;
    logic        rwds_out, rwds_oe, rwds_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ca_rd [6] = '{8'hA2, 8'h46, 8'h8A, 8'hCF, 8'h00, 8'h00};
    logic [7:0] ca_wr [6] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] rd_b  [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] wr_b  [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    logic       wr_rw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    int done_cyc, n_done, n_err;
    logic [31:0] data_at_done;
    logic        err_at_done;

    hyperram_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .transaction_begin(transaction_begin),
        .write_enable(write_enable), .address(address), .write_mask(write_mask),
        .data_in(data_in), .wait_latency(wait_latency), .done_latency(done_latency),
        .timed_read(timed_read), .data_out(data_out), .busy(busy), .done(done),
        .error(error), .ck(ck), .cs_n(cs_n), .dq_out(dq_out), .dq_oe(dq_oe),
        .dq_in(dq_in), .rwds_out(rwds_out), .rwds_oe(rwds_oe), .rwds_in(rwds_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1: the first CA cycle after the request edge.
    task automatic start(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [5:0] wl, input logic [5:0] dl,
                         input logic timed);
        write_enable = we; address = addr; write_mask = mask; data_in = data;
        wait_latency = wl; done_latency = dl; timed_read = timed;
        rwds_in = 1'b0; dq_in = 8'h00;
        transaction_begin = 1'b1;
        tick();
        transaction_begin = 1'b0;
    endtask

    task automatic track(input int k);
        if (done) begin
            n_done++;
            if (done_cyc == 0) begin
                done_cyc = k; data_at_done = data_out; err_at_done = error;
            end
        end
        if (error) n_err++;
    endtask

    initial begin
        rst = 1'b1; transaction_begin = 1'b0; write_enable = 1'b0; address = '0;
        write_mask = '0; data_in = '0; wait_latency = '0; done_latency = '0;
        timed_read = 1'b0; dq_in = '0; rwds_in = 1'b0;
        tick(); tick();
        chk("rst_outs", {busy, done, error, ck, cs_n, dq_oe, rwds_out, rwds_oe}, 8'b0000_1000);
        chk("rst_dq_out", dq_out, 8'h00);
        chk("rst_data_out", data_out, 32'h0);
        rst = 1'b0;
        tick();

        // Timed read, no latency.
        start(1'b0, 32'h1234_5678, 4'hF, 32'h0, 6'd0, 6'd0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k <= 6) begin
                chk("rd_ca_byte", dq_out, ca_rd[k-1]);
                chk("rd_ca_oe_cs", {dq_oe, cs_n}, 2'b10);
            end
            if (k == 1) chk("rd_ck_c1", ck, 1'b0);
            if (k == 2) chk("rd_ck_c2", ck, 1'b1);
            if (k >= 7 && k <= 10) begin
                chk("rd_dq_oe", dq_oe, 1'b0);
                dq_in = rd_b[k-7];
            end
            if (k == 10) chk("rd_partial", data_out, 32'hDEAD_BE00);
            if (k == 11) begin
                chk("rd_done", {done, error, cs_n}, 3'b101);
                chk("rd_data", data_out, 32'hDEAD_BEEF);
            end
            if (k == 12) chk("rd_idle", {done, busy, ck, cs_n}, 4'b0001);
            tick();
        end

        // Write with mask 1010.
        start(1'b1, 32'h0000_0001, 4'b1010, 32'hCAFE_F00D, 6'd0, 6'd0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            if (k <= 6) chk("wr_ca_byte", dq_out, ca_wr[k-1]);
            if (k >= 7 && k <= 10) begin
                chk("wr_byte", dq_out, wr_b[k-7]);
                chk("wr_rwds", rwds_out, wr_rw[k-7]);
                chk("wr_oe", {dq_oe, rwds_oe, cs_n}, 3'b110);
            end
            if (k == 10) chk("wr_ck_last", ck, 1'b1);
            if (k == 11) begin
                chk("wr_done", {done, ck, rwds_oe, dq_oe}, 4'b1000);
                chk("wr_no_dout", data_out, 32'hDEAD_BEEF);
            end
            tick();
        end

        // Latency 3, recovery 2.
        done_cyc = 0; n_done = 0; n_err = 0;
        start(1'b1, 32'h0000_0040, 4'hF, 32'h0102_0304, 6'd3, 6'd2, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            track(k);
            if (k >= 7 && k <= 12) chk("lat_bus", {cs_n, dq_oe}, 2'b00);
            if (k >= 13 && k <= 16) chk("lat_data", {dq_oe, dq_out}, {1'b1, 8'(k - 12)});
            if (k == 16) chk("lat_ck_last", ck, 1'b1);
            if (k >= 17 && k <= 20) chk("lat_rec", {cs_n, dq_oe, rwds_oe, ck, done}, 5'b0);
            tick();
        end
        chk("lat_done_cyc", done_cyc, 21);
        chk("lat_n_done", n_done, 1);
        chk("lat_ck_end", ck, 1'b0);

        // Untimed read, rwds toggling every 2 cycles.
        done_cyc = 0; n_done = 0; n_err = 0;
        start(1'b0, 32'h0000_0100, 4'hF, 32'h0, 6'd0, 6'd0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            track(k);
            if (k >= 8 && k <= 14) begin
                rwds_in = (((k - 8) / 2) % 2) == 0;
                dq_in   = 8'(8'h11 * ((k - 8) / 2 + 1));
            end
            tick();
        end
        chk("ut_done_cyc", done_cyc, 15);
        chk("ut_data", data_at_done, 32'h1122_3344);
        chk("ut_err", n_err, 0);

        // Untimed read: two bytes then rwds stuck low, expect timeout.
        done_cyc = 0; n_done = 0; n_err = 0;
        start(1'b0, 32'h0000_0200, 4'hF, 32'h0, 6'd0, 6'd0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            track(k);
            if (k == 8)  begin rwds_in = 1'b1; dq_in = 8'hAA; end
            if (k == 10) begin rwds_in = 1'b0; dq_in = 8'hBB; end
            tick();
        end
        chk("to_done_cyc", done_cyc, 266);
        chk("to_err_at_done", err_at_done, 1'b1);
        chk("to_err_pulses", n_err, 1);
        chk("to_data", data_at_done, 32'hAABB_3344);

        // Reset during the 3rd CA cycle.
        done_cyc = 0; n_done = 0; n_err = 0;
        start(1'b1, 32'h0000_0008, 4'hF, 32'h5555_AAAA, 6'd0, 6'd0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mid_rst", {cs_n, busy, dq_oe, ck}, 4'b1000);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            track(k);
            tick();
        end
        chk("mid_rst_no_done", n_done, 0);

        // Request while busy is ignored.
        done_cyc = 0; n_done = 0; n_err = 0;
        start(1'b0, 32'h1234_5678, 4'hF, 32'h0, 6'd0, 6'd0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            track(k);
            if (k == 4) transaction_begin = 1'b1;
            if (k == 5) transaction_begin = 1'b0;
            if (k == 12) chk("ign_idle", {busy, cs_n}, 2'b01);
            tick();
        end
        chk("ign_done_cyc", done_cyc, 11);
        chk("ign_n_done", n_done, 1);
        chk("ign_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
